// File: rtl/ifid_hazard_stage_pkg.sv
// Shared definitions for the IF/ID register and hazard sequencer.
package ifid_hazard_stage_pkg;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;   // addi x0,x0,0

   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_S     = 7'b0100011;
   localparam logic [6:0] OP_B     = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;
   localparam logic [6:0] OP_SYS   = 7'b1110011;

   // Sequencer states
   localparam logic [0:0] ST_RUN    = 1'b0;
   localparam logic [0:0] ST_SQUASH = 1'b1;

   // Squash countdown width; covers IMEM_LATENCY-1 up to 6
   localparam int unsigned SQ_W = 3;

   // Opcodes that carry no rs1 operand
   function automatic logic uses_rs1(input logic [6:0] op);
      return !((op == OP_LUI) || (op == OP_AUIPC) || (op == OP_JAL));
   endfunction

   // Only register-register, store and branch read rs2
   function automatic logic uses_rs2(input logic [6:0] op);
      return (op == OP_R) || (op == OP_S) || (op == OP_B);
   endfunction

endpackage

// File: rtl/ifid_hazard_stage_sat_counter.sv
// Saturating up-counter with enable; holds at all-ones instead of wrapping.
module sat_counter #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   output logic [WIDTH-1:0] count
);

   logic [WIDTH-1:0] cnt_q;
   logic [WIDTH-1:0] cnt_d;

   // Next count: increment when enabled and not yet saturated
   always_comb begin
      cnt_d = cnt_q;
      if (en && (cnt_q != {WIDTH{1'b1}})) begin
         cnt_d = cnt_q + WIDTH'(1);
      end
   end

   // Count register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign count = cnt_q;

endmodule

// File: rtl/ifid_hazard_stage.sv
// IF/ID pipeline register with load-use stall and redirect squash sequencing.
module ifid_hazard_stage
   import ifid_hazard_stage_pkg::*;
#(
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned IMEM_LATENCY = 1,
   parameter int unsigned CNT_WIDTH    = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] instr_f,
   input  logic [DATA_WIDTH-1:0] pc_f,
   input  logic                  ex_memread,
   input  logic [4:0]            ex_rd,
   input  logic                  redirect_e,
   output logic [DATA_WIDTH-1:0] instr_d,
   output logic [DATA_WIDTH-1:0] pc_d,
   output logic                  valid_d,
   output logic                  stall,
   output logic                  stall_f,
   output logic                  flush_e,
   output logic [CNT_WIDTH-1:0]  stall_cnt,
   output logic [CNT_WIDTH-1:0]  flush_cnt
);

   localparam logic [SQ_W-1:0] SQ_RELOAD = SQ_W'(IMEM_LATENCY - 1);

   logic [DATA_WIDTH-1:0] dec_instr_q, dec_instr_d;
   logic [DATA_WIDTH-1:0] dec_pc_q,    dec_pc_d;
   logic                  dec_valid_q, dec_valid_d;
   logic [0:0]            state_q,     state_d;
   logic [SQ_W-1:0]       sq_cnt_q,    sq_cnt_d;

   logic [6:0] opcode;
   logic [4:0] rs1, rs2;
   logic       hz;
   logic       flush_inc;

   // Load-use detection against the instruction sitting in decode
   always_comb begin
      opcode = dec_instr_q[6:0];
      rs1    = dec_instr_q[19:15];
      rs2    = dec_instr_q[24:20];
      hz     = dec_valid_q && ex_memread && (ex_rd != 5'd0) &&
               ((uses_rs1(opcode) && (ex_rd == rs1)) ||
                (uses_rs2(opcode) && (ex_rd == rs2)));
   end

   // Control outputs; a redirect overrides the stall since the stalled slot dies anyway
   assign stall_f = hz && !redirect_e;
   assign flush_e = hz || redirect_e;
   assign stall   = !dec_valid_q || (hz && !redirect_e);

   // Sequencer next state: redirect > hazard hold > normal advance
   always_comb begin
      dec_instr_d = dec_instr_q;
      dec_pc_d    = dec_pc_q;
      dec_valid_d = dec_valid_q;
      state_d     = state_q;
      sq_cnt_d    = sq_cnt_q;
      flush_inc   = 1'b0;

      case (state_q)
         ST_RUN: begin
            if (redirect_e) begin
               dec_instr_d = DATA_WIDTH'(NOP_INSTR);
               dec_valid_d = 1'b0;
               flush_inc   = 1'b1;
               if (IMEM_LATENCY > 1) begin
                  state_d  = ST_SQUASH;
                  sq_cnt_d = SQ_RELOAD;
               end
            end else if (!hz) begin
               dec_instr_d = instr_f;
               dec_pc_d    = pc_f;
               dec_valid_d = 1'b1;
            end
         end
         ST_SQUASH: begin
            dec_instr_d = DATA_WIDTH'(NOP_INSTR);
            dec_valid_d = 1'b0;
            flush_inc   = 1'b1;
            if (redirect_e) begin
               sq_cnt_d = SQ_RELOAD;
            end else begin
               sq_cnt_d = sq_cnt_q - SQ_W'(1);
               if (sq_cnt_q == SQ_W'(1)) begin
                  state_d = ST_RUN;
               end
            end
         end
         default: begin
            state_d = ST_RUN;
         end
      endcase
   end

   // Pipeline and sequencer registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dec_instr_q <= DATA_WIDTH'(NOP_INSTR);
         dec_pc_q    <= '0;
         dec_valid_q <= 1'b0;
         state_q     <= ST_RUN;
         sq_cnt_q    <= '0;
      end else begin
         dec_instr_q <= dec_instr_d;
         dec_pc_q    <= dec_pc_d;
         dec_valid_q <= dec_valid_d;
         state_q     <= state_d;
         sq_cnt_q    <= sq_cnt_d;
      end
   end

   assign instr_d = dec_instr_q;
   assign pc_d    = dec_pc_q;
   assign valid_d = dec_valid_q;

   sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .en    (stall_f),
      .count (stall_cnt)
   );

   sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
      .clk   (clk),
      .rst   (rst),
      .en    (flush_inc),
      .count (flush_cnt)
   );

endmodule

// File: doc/ifid_hazard_stage.md
Name: ifid_hazard_stage

Overview:
- IF/ID pipeline register combined with the hazard sequencer that drives the instruction decoder.
- Captures each fetched instruction and its PC and presents them to decode as instr_d.
- Detects load-use hazards and squashes wrong-path instructions after a taken branch or jump.
- Generates the stall input of the decoder, the PC freeze for fetch, and the bubble request for ID/EX.

Parameters:
DATA_WIDTH, 32, instruction/PC width
IMEM_LATENCY, 1, cycles after a redirect during which fetch output is stale and must be squashed (1..7)
CNT_WIDTH, 32, width of saturating performance counters

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
instr_f  in  DATA_WIDTH  instruction from instruction memory
pc_f  in  DATA_WIDTH  PC of instr_f
ex_memread  in  1  ID/EX stage holds a load
ex_rd  in  5  destination register of ID/EX instruction
redirect_e  in  1  branch/jump resolved taken in execute
instr_d  out  DATA_WIDTH  instruction presented to decoder
pc_d  out  DATA_WIDTH  PC of instr_d
valid_d  out  1  instr_d is a live instruction
stall  out  1  decoder must suppress RegWrite/MemWrite
stall_f  out  1  hold PC and fetch
flush_e  out  1  load bubble into ID/EX this cycle
stall_cnt  out  CNT_WIDTH  load-use stall cycles
flush_cnt  out  CNT_WIDTH  squashed fetch slots

Behaviour:
- Reset (async, rst=1):
  - instr_d=32'h00000013 (NOP), pc_d=0, valid_d=0.
  - state=RUN, squash counter=0, both perf counters=0.
  - stall=1 (because valid_d=0); stall_f=0; flush_e=0.
- Operand usage decode of instr_d:
  - rs1 used for every opcode except lui (0110111), auipc (0010111) and jal (1101111).
  - rs2 used only for R (0110011), S (0100011) and B (1100011).
- Hazard condition: hz = valid_d & ex_memread & (ex_rd!=0) & ((uses_rs1 & ex_rd==instr_d[19:15]) | (uses_rs2 & ex_rd==instr_d[24:20])).
- Outputs:
  - Combinational: stall_f = hz & ~redirect_e; flush_e = hz | redirect_e.
  - Combinational: stall = ~valid_d | (hz & ~redirect_e).
  - Registered: instr_d, pc_d, valid_d.
- FSM states: RUN, SQUASH.
  - RUN, redirect_e=1:
    - next cycle instr_d=NOP, valid_d=0.
    - If IMEM_LATENCY>1, go to SQUASH with count=IMEM_LATENCY-1; else stay in RUN.
  - RUN, hz=1 (no redirect): hold instr_d/pc_d/valid_d unchanged. A hold lasts one cycle, because the bubble clears ex_memread.
  - RUN, otherwise: load instr_f/pc_f, valid_d=1.
  - SQUASH: each cycle load NOP with valid_d=0 and decrement count; at count reaching 0 return to RUN on the next edge.
  - SQUASH, redirect_e=1: reload count=IMEM_LATENCY-1 (restart squash).
- Priority: redirect_e > hz > normal advance. A redirect in the same cycle as hz squashes; stall_f=0.
- Latency: instr_f appears on instr_d one cycle later when no hazard is present.
- Counters:
  - stall_cnt increments on each cycle with stall_f=1.
  - flush_cnt increments on each edge that loads a squash NOP (redirect or SQUASH).
  - Both saturate at all-ones, with no wrap.
- Reset mid-SQUASH or mid-stall: immediately returns to the reset values.

Decomposition:
- Shared package (def.sv): NOP encoding; opcode constants OP_R, OP_I, OP_LOAD, OP_S, OP_B, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, OP_SYS; FSM state enum.
- One sub-module: sat_counter (parameterised width, enable, async reset), instantiated twice.

Test Plan:
- Reset: assert rst for 2 cycles then release, instr_f=addi x1,x0,5 at pc 0x0 -> during reset instr_d=0x00000013, valid_d=0, stall=1; one cycle after release instr_d=0x00500093, pc_d=0, valid_d=1, stall=0.
- Load-use: instr_d=add x3,x1,x2 with ex_memread=1, ex_rd=1 -> stall_f=1, flush_e=1, stall=1 for exactly one cycle; instr_d held; stall_cnt=1. Same case with ex_rd=0 -> no stall.
- Non-use: instr_d=lui x5,0x12345 with ex_memread=1, ex_rd=5 -> no stall. instr_d=addi x4,x2,1 with ex_rd=2 -> stall (rs1 match). sw x2,0(x6) with ex_rd=2 -> stall (rs2 match).
- Redirect, IMEM_LATENCY=2: pulse redirect_e for 1 cycle -> instr_d=NOP, valid_d=0 for 2 cycles, then the new target's instruction loads; flush_cnt=2.
- Simultaneous events: hz=1 and redirect_e=1 in the same cycle -> stall_f=0, flush_e=1, instr_d becomes NOP. A second redirect_e during SQUASH restarts the count.
- Saturation: CNT_WIDTH=4, force 20 load-use stalls -> stall_cnt stops at 4'hF. Assert rst mid-SQUASH -> counters=0, state RUN.
